// File: rtl/dragonfang_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dragonfang_pkg
// Brief    : Shared vector types, vlmul encodings, merge sequencer state
//            enum and the vlmul to register-group-size helper.
// Revision : 1.0 - initial release
// ============================================================================
package dragonfang_pkg;

    // vlmul encodings
    localparam logic [2:0] c_vlmul_m1       = 3'b000;
    localparam logic [2:0] c_vlmul_m2       = 3'b001;
    localparam logic [2:0] c_vlmul_m4       = 3'b010;
    localparam logic [2:0] c_vlmul_m8       = 3'b011;
    localparam logic [2:0] c_vlmul_reserved = 3'b100;
    localparam logic [2:0] c_vlmul_mf8      = 3'b101;
    localparam logic [2:0] c_vlmul_mf4      = 3'b110;
    localparam logic [2:0] c_vlmul_mf2      = 3'b111;

    // Decoded control forwarded untouched to the merge unit
    typedef struct packed {
        logic [5:0] funct6;
        logic       vm;
        logic [2:0] vsew;
        logic [2:0] frm;
    } execution_vector_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } merge_seq_state_t;

    // Fractional and reserved encodings occupy a single register; the
    // reserved case is rejected separately by the issue check.
    function automatic logic [3:0] lmul_to_group_size(input logic [2:0] vlmul);
        logic [3:0] size;
        case (vlmul)
            c_vlmul_m2: size = 4'd2;
            c_vlmul_m4: size = 4'd4;
            c_vlmul_m8: size = 4'd8;
            default:    size = 4'd1;
        endcase
        return size;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with arbitrary depth; pointers wrap modulo
//            DEPTH. Pushes into a full FIFO are dropped unless a pop frees
//            a slot in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_full;
    logic               w_push;
    logic               w_pop;

    function automatic logic [c_ptr_w-1:0] next_ptr(input logic [c_ptr_w-1:0] ptr);
        return (ptr == c_ptr_w'(DEPTH - 1)) ? '0 : ptr + c_ptr_w'(1);
    endfunction

    assign o_empty = (r_count == '0);
    assign w_full  = (r_count == c_cnt_w'(DEPTH));
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~w_full | w_pop);
    assign o_data  = r_mem[r_rd_ptr];

    // Storage array: written on accepted push, no reset needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/vector_floating_point_merge_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vector_floating_point_merge_sequencer
// Brief    : Steps one vfmerge across its LMUL register group through a
//            fixed-latency merge unit, tracks in-flight results with a tag
//            pipeline and buffers them for a backpressured writeback port.
//            Credits bound in-flight plus buffered results to the FIFO depth.
// Revision : 1.0 - initial release
// ============================================================================
module vector_floating_point_merge_sequencer
    import dragonfang_pkg::*;
#(
    parameter int VLEN              = 128,
    parameter int UNIT_LATENCY      = 2,
    parameter int RESULT_FIFO_DEPTH = 4,
    parameter int REG_ADDR_WIDTH    = 5
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      issue_valid,
    output logic                      issue_ready,
    input  execution_vector_t         issue_execution_vector,
    input  logic [2:0]                issue_lmul,
    input  logic [REG_ADDR_WIDTH-1:0] issue_vd_addr,
    input  logic [REG_ADDR_WIDTH-1:0] issue_vs2_addr,
    input  logic [REG_ADDR_WIDTH-1:0] issue_vs1_addr,
    output logic [REG_ADDR_WIDTH-1:0] rf_vs2_addr,
    output logic [REG_ADDR_WIDTH-1:0] rf_vs1_addr,
    input  logic [VLEN-1:0]           rf_vs2_data,
    input  logic [VLEN-1:0]           rf_vs1_data,
    output execution_vector_t         unit_execution_vector,
    output logic [VLEN-1:0]           unit_vs2,
    output logic [VLEN-1:0]           unit_vs1,
    input  logic [VLEN-1:0]           unit_vd,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic [REG_ADDR_WIDTH-1:0] wb_addr,
    output logic [VLEN-1:0]           wb_data,
    output logic                      busy,
    output logic                      done,
    output logic                      illegal
);

    localparam int                c_credit_w     = $clog2(RESULT_FIFO_DEPTH + 1);
    localparam logic [c_credit_w-1:0] c_full_credits = c_credit_w'(RESULT_FIFO_DEPTH);
    localparam int                c_entry_w      = REG_ADDR_WIDTH + VLEN;

    merge_seq_state_t              r_state;
    merge_seq_state_t              w_state_next;
    execution_vector_t             r_exec_vec;
    logic [REG_ADDR_WIDTH-1:0]     r_vd_base;
    logic [REG_ADDR_WIDTH-1:0]     r_vs2_base;
    logic [REG_ADDR_WIDTH-1:0]     r_vs1_base;
    logic [3:0]                    r_group_size;
    logic [3:0]                    r_counter;
    logic [c_credit_w-1:0]         r_credits;
    logic                          r_illegal;
    logic [UNIT_LATENCY-1:0]       r_tag_valid;
    logic [UNIT_LATENCY-1:0][REG_ADDR_WIDTH-1:0] r_tag_addr;

    logic [3:0]                    w_issue_group_size;
    logic [REG_ADDR_WIDTH-1:0]     w_align_mask;
    logic                          w_issue_illegal;
    logic                          w_issue_accept;
    logic                          w_elem_issue;
    logic                          w_last_elem;
    logic                          w_wb_fire;
    logic                          w_fifo_empty;
    logic [c_entry_w-1:0]          w_fifo_head;

    // Issue legality: reserved vlmul or any base not aligned to the group
    assign w_issue_group_size = lmul_to_group_size(issue_lmul);
    assign w_align_mask       = REG_ADDR_WIDTH'(w_issue_group_size - 4'd1);
    assign w_issue_illegal    = (issue_lmul == c_vlmul_reserved)
                              | (|(issue_vd_addr  & w_align_mask))
                              | (|(issue_vs2_addr & w_align_mask))
                              | (|(issue_vs1_addr & w_align_mask));
    assign w_issue_accept     = (r_state == IDLE) & issue_valid;

    // An element goes out only while a result slot is reserved for it
    assign w_elem_issue = (r_state == RUN) & (r_credits != '0);
    assign w_last_elem  = (r_counter == (r_group_size - 4'd1));
    assign w_wb_fire    = wb_valid & wb_ready;

    assign busy    = (r_state != IDLE);
    assign illegal = r_illegal;

    // RF reads and unit drive: data passes straight through to the unit
    assign rf_vs2_addr           = (r_state == RUN) ? r_vs2_base + REG_ADDR_WIDTH'(r_counter) : '0;
    assign rf_vs1_addr           = (r_state == RUN) ? r_vs1_base + REG_ADDR_WIDTH'(r_counter) : '0;
    assign unit_vs2              = rf_vs2_data;
    assign unit_vs1              = rf_vs1_data;
    assign unit_execution_vector = busy ? r_exec_vec : '0;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        w_state_next = r_state;
        issue_ready  = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                issue_ready = 1'b1;
                if (issue_valid && !w_issue_illegal) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_elem_issue && w_last_elem) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Every credit back means every result has been written back
                if (r_credits == c_full_credits) begin
                    done         = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Instruction context latch and element counter
    always_ff @(posedge clock) begin
        if (reset) begin
            r_exec_vec   <= '0;
            r_vd_base    <= '0;
            r_vs2_base   <= '0;
            r_vs1_base   <= '0;
            r_group_size <= 4'd1;
            r_counter    <= '0;
        end else if (w_issue_accept && !w_issue_illegal) begin
            r_exec_vec   <= issue_execution_vector;
            r_vd_base    <= issue_vd_addr;
            r_vs2_base   <= issue_vs2_addr;
            r_vs1_base   <= issue_vs1_addr;
            r_group_size <= w_issue_group_size;
            r_counter    <= '0;
        end else if (w_elem_issue) begin
            r_counter    <= r_counter + 4'd1;
        end
    end

    // Illegal issue pulse, one cycle after the rejected offer
    always_ff @(posedge clock) begin
        if (reset) begin
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_issue_accept & w_issue_illegal;
        end
    end

    // Credits: taken on element issue, returned on writeback handshake
    always_ff @(posedge clock) begin
        if (reset) begin
            r_credits <= c_full_credits;
        end else begin
            case ({w_elem_issue, w_wb_fire})
                2'b10:   r_credits <= r_credits - c_credit_w'(1);
                2'b01:   r_credits <= r_credits + c_credit_w'(1);
                default: r_credits <= r_credits;
            endcase
        end
    end

    // Tag pipeline aligned with the unit latency; bubbles carry valid=0
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tag_valid <= '0;
            r_tag_addr  <= '0;
        end else begin
            r_tag_valid[0] <= w_elem_issue;
            r_tag_addr[0]  <= r_vd_base + REG_ADDR_WIDTH'(r_counter);
            for (int i = 1; i < UNIT_LATENCY; i++) begin
                r_tag_valid[i] <= r_tag_valid[i-1];
                r_tag_addr[i]  <= r_tag_addr[i-1];
            end
        end
    end

    sync_fifo #(
        .WIDTH (c_entry_w),
        .DEPTH (RESULT_FIFO_DEPTH)
    ) u_result_fifo (
        .clk     (clock),
        .rst     (reset),
        .i_push  (r_tag_valid[UNIT_LATENCY-1]),
        .i_data  ({r_tag_addr[UNIT_LATENCY-1], unit_vd}),
        .i_pop   (w_wb_fire),
        .o_data  (w_fifo_head),
        .o_empty (w_fifo_empty)
    );

    // Writeback port presents the FIFO head; zero when nothing is buffered
    assign wb_valid = ~w_fifo_empty;
    assign wb_addr  = wb_valid ? w_fifo_head[c_entry_w-1:VLEN] : '0;
    assign wb_data  = wb_valid ? w_fifo_head[VLEN-1:0] : '0;

endmodule
`default_nettype wire

// File: tb/tb_vector_floating_point_merge_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_floating_point_merge_sequencer
// Brief    : Directed bench with a transaction-level expected-writeback
//            queue, a behavioural RF and a 2-stage merge unit model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_vector_floating_point_merge_sequencer;
    import dragonfang_pkg::*;

    localparam int VLEN  = 128;
    localparam int UL    = 2;
    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam logic [VLEN-1:0] c_mask = {32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h0};

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              issue_valid = 1'b0;
    logic              issue_ready;
    execution_vector_t issue_execution_vector = '0;
    logic [2:0]        issue_lmul = 3'b000;
    logic [AW-1:0]     issue_vd_addr = '0;
    logic [AW-1:0]     issue_vs2_addr = '0;
    logic [AW-1:0]     issue_vs1_addr = '0;
    logic [AW-1:0]     rf_vs2_addr, rf_vs1_addr;
    logic [VLEN-1:0]   rf_vs2_data, rf_vs1_data;
    execution_vector_t unit_execution_vector;
    logic [VLEN-1:0]   unit_vs2, unit_vs1, unit_vd;
    logic              wb_valid;
    logic              wb_ready = 1'b1;
    logic [AW-1:0]     wb_addr;
    logic [VLEN-1:0]   wb_data;
    logic              busy, done, illegal;

    int n_checks = 0;
    int n_pass   = 0;
    logic [AW+VLEN-1:0] exp_q[$];
    logic [VLEN-1:0]    u_s1, u_s2;
    execution_vector_t  ev1, ev2;

    always #5 clock = ~clock;

    vector_floating_point_merge_sequencer #(
        .VLEN(VLEN), .UNIT_LATENCY(UL), .RESULT_FIFO_DEPTH(DEPTH), .REG_ADDR_WIDTH(AW)
    ) dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_execution_vector(issue_execution_vector), .issue_lmul(issue_lmul),
        .issue_vd_addr(issue_vd_addr), .issue_vs2_addr(issue_vs2_addr), .issue_vs1_addr(issue_vs1_addr),
        .rf_vs2_addr(rf_vs2_addr), .rf_vs1_addr(rf_vs1_addr),
        .rf_vs2_data(rf_vs2_data), .rf_vs1_data(rf_vs1_data),
        .unit_execution_vector(unit_execution_vector), .unit_vs2(unit_vs2), .unit_vs1(unit_vs1),
        .unit_vd(unit_vd),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .busy(busy), .done(done), .illegal(illegal)
    );

    // Register file: every byte of register a holds the value a
    function automatic logic [VLEN-1:0] rf_word(input logic [AW-1:0] a);
        return {16{3'b000, a}};
    endfunction

    // Merge unit behaviour: lanes 3 and 1 from vs1, lanes 2 and 0 from vs2
    function automatic logic [VLEN-1:0] merge(input logic [VLEN-1:0] vs2, input logic [VLEN-1:0] vs1);
        return (vs1 & c_mask) | (vs2 & ~c_mask);
    endfunction

    function automatic int group_of(input logic [2:0] lmul);
        case (lmul)
            3'b001:  return 2;
            3'b010:  return 4;
            3'b011:  return 8;
            default: return 1;
        endcase
    endfunction

    assign rf_vs2_data = rf_word(rf_vs2_addr);
    assign rf_vs1_data = rf_word(rf_vs1_addr);

    always @(posedge clock) begin
        u_s1 <= merge(unit_vs2, unit_vs1);
        u_s2 <= u_s1;
    end
    assign unit_vd = u_s2;

    task automatic chk(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Offer one instruction for one cycle; on return the bench is in cycle 1
    task automatic issue(input execution_vector_t ev, input logic [2:0] lmul,
                         input logic [AW-1:0] vd, input logic [AW-1:0] vs2, input logic [AW-1:0] vs1);
        int g;
        bit legal;
        @(posedge clock); #1;
        issue_execution_vector = ev;
        issue_lmul     = lmul;
        issue_vd_addr  = vd;
        issue_vs2_addr = vs2;
        issue_vs1_addr = vs1;
        issue_valid    = 1'b1;
        @(posedge clock); #1;
        issue_valid = 1'b0;
        g = group_of(lmul);
        legal = (lmul != 3'b100) && (int'(vd) % g == 0) && (int'(vs2) % g == 0) && (int'(vs1) % g == 0);
        if (legal) begin
            for (int i = 0; i < g; i++) begin
                exp_q.push_back({AW'(int'(vd) + i),
                                 merge(rf_word(AW'(int'(vs2) + i)), rf_word(AW'(int'(vs1) + i)))});
            end
        end
    endtask

    task automatic wait_done(input int limit);
        bit found;
        found = 1'b0;
        for (int k = 0; k < limit && !found; k++) begin
            @(negedge clock);
            if (done === 1'b1) found = 1'b1;
        end
        chk("done_seen", VLEN'(found), 1);
    endtask

    // Writeback scoreboard: head must match the next expected result
    always @(negedge clock) begin
        logic [AW+VLEN-1:0] e;
        if (!reset && wb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("wb_unexpected", VLEN'(wb_valid), 0);
            end else begin
                e = exp_q[0];
                chk("wb_addr", VLEN'(wb_addr), VLEN'(e[AW+VLEN-1:VLEN]));
                chk("wb_data", wb_data, e[VLEN-1:0]);
                if (wb_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        ev1 = '{funct6: 6'b010111, vm: 1'b0, vsew: 3'b010, frm: 3'b000};
        ev2 = '{funct6: 6'b010111, vm: 1'b1, vsew: 3'b011, frm: 3'b001};

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_issue_ready", VLEN'(issue_ready), 1);
        chk("rst_wb_valid", VLEN'(wb_valid), 0);
        chk("rst_busy", VLEN'(busy), 0);
        chk("rst_done", VLEN'(done), 0);
        chk("rst_illegal", VLEN'(illegal), 0);
        chk("rst_wb_addr", VLEN'(wb_addr), 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_unit_ev", VLEN'(unit_execution_vector), 0);
        @(posedge clock); #1;
        reset = 1'b0;

        // LMUL=1 latency
        issue(ev1, 3'b000, 5'd4, 5'd8, 5'd12);
        @(negedge clock);
        chk("t1_rf_vs2", VLEN'(rf_vs2_addr), 8);
        chk("t1_rf_vs1", VLEN'(rf_vs1_addr), 12);
        chk("t1_busy", VLEN'(busy), 1);
        chk("t1_issue_ready", VLEN'(issue_ready), 0);
        chk("t1_unit_ev", VLEN'(unit_execution_vector), VLEN'(ev1));
        repeat (2) @(negedge clock);
        chk("t1_c3_wb_valid", VLEN'(wb_valid), 0);
        @(negedge clock);
        chk("t1_c4_wb_valid", VLEN'(wb_valid), 1);
        chk("t1_c4_wb_addr", VLEN'(wb_addr), 4);
        chk("t1_c4_wb_data", wb_data, 128'h0C0C0C0C_08080808_0C0C0C0C_08080808);
        @(negedge clock);
        chk("t1_c5_done", VLEN'(done), 1);
        @(negedge clock);
        chk("t1_c6_done", VLEN'(done), 0);
        chk("t1_c6_busy", VLEN'(busy), 0);
        chk("t1_empty", VLEN'(exp_q.size()), 0);

        // LMUL=8 streaming, no bubbles
        issue(ev2, 3'b011, 5'd8, 5'd16, 5'd24);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            if (c <= 8) chk("t2_rf_vs2", VLEN'(rf_vs2_addr), VLEN'(16 + c - 1));
            if (c >= 4 && c <= 11) begin
                chk("t2_wb_valid", VLEN'(wb_valid), 1);
                chk("t2_wb_addr", VLEN'(wb_addr), VLEN'(8 + c - 4));
            end
            chk("t2_done", VLEN'(done), VLEN'(c == 12));
        end
        @(negedge clock);
        chk("t2_busy_end", VLEN'(busy), 0);
        chk("t2_empty", VLEN'(exp_q.size()), 0);

        // LMUL=8 under a 20-cycle writeback stall
        wb_ready = 1'b0;
        issue(ev2, 3'b011, 5'd8, 5'd16, 5'd24);
        repeat (20) @(negedge clock);
        chk("t3_rf_vs2_stuck", VLEN'(rf_vs2_addr), 20);
        chk("t3_wb_valid", VLEN'(wb_valid), 1);
        chk("t3_wb_addr", VLEN'(wb_addr), 8);
        chk("t3_busy", VLEN'(busy), 1);
        chk("t3_done", VLEN'(done), 0);
        @(posedge clock); #1;
        wb_ready = 1'b1;
        wait_done(40);
        chk("t3_empty", VLEN'(exp_q.size()), 0);

        // Illegal issues: misaligned vd, then reserved vlmul
        issue(ev1, 3'b010, 5'd6, 5'd8, 5'd12);
        @(negedge clock);
        chk("t4a_illegal", VLEN'(illegal), 1);
        chk("t4a_issue_ready", VLEN'(issue_ready), 1);
        chk("t4a_busy", VLEN'(busy), 0);
        chk("t4a_rf_vs2", VLEN'(rf_vs2_addr), 0);
        chk("t4a_wb_valid", VLEN'(wb_valid), 0);
        @(negedge clock);
        chk("t4a_illegal_off", VLEN'(illegal), 0);
        issue(ev1, 3'b100, 5'd0, 5'd8, 5'd16);
        @(negedge clock);
        chk("t4b_illegal", VLEN'(illegal), 1);
        chk("t4b_busy", VLEN'(busy), 0);
        @(negedge clock);
        chk("t4b_illegal_off", VLEN'(illegal), 0);
        chk("t4b_wb_valid", VLEN'(wb_valid), 0);

        // LMUL=4 with wb_ready toggling every cycle
        issue(ev1, 3'b010, 5'd4, 5'd8, 5'd12);
        begin
            bit found;
            found = 1'b0;
            for (int k = 0; k < 60 && !found; k++) begin
                @(posedge clock); #1;
                wb_ready = ~wb_ready;
                @(negedge clock);
                if (done === 1'b1) found = 1'b1;
            end
            chk("t5_done_seen", VLEN'(found), 1);
        end
        chk("t5_empty", VLEN'(exp_q.size()), 0);
        @(posedge clock); #1;
        wb_ready = 1'b1;

        // Reset in the middle of an LMUL=8 run
        issue(ev2, 3'b011, 5'd8, 5'd16, 5'd24);
        repeat (3) @(negedge clock);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clock);
        chk("t6_busy", VLEN'(busy), 0);
        chk("t6_wb_valid", VLEN'(wb_valid), 0);
        chk("t6_issue_ready", VLEN'(issue_ready), 1);
        issue(ev1, 3'b000, 5'd1, 5'd3, 5'd5);
        wait_done(20);
        chk("t6_empty", VLEN'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vector_floating_point_merge_sequencer.md
Name: vector_floating_point_merge_sequencer

Overview:
Sequences one vfmerge instruction across its LMUL register group through the registered FP merge unit (vector_floating_point_merge_unit_freq, fixed latency UNIT_LATENCY, no stall input). It accepts an issued instruction, steps register-file reads one group member per cycle and tracks in-flight results with a tag pipeline. Results are buffered in a result FIFO that feeds a backpressured writeback port. Credit-based issue guarantees that no result is ever lost under writeback stall.

Parameters:
VLEN, 128, vector register width in bits.
UNIT_LATENCY, 2, cycles from unit input drive to valid unit_vd.
RESULT_FIFO_DEPTH, 4, result buffer entries; must be >= UNIT_LATENCY+1.
REG_ADDR_WIDTH, 5, vector register address width.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
issue_valid  in  1  instruction offered
issue_ready  out  1  sequencer can accept
issue_execution_vector  in  execution_vector_t  decoded control, forwarded to unit
issue_lmul  in  3  vlmul encoding
issue_vd_addr / issue_vs2_addr / issue_vs1_addr  in  REG_ADDR_WIDTH each  group base registers
rf_vs2_addr / rf_vs1_addr  out  REG_ADDR_WIDTH each  combinational RF read addresses
rf_vs2_data / rf_vs1_data  in  VLEN each  same-cycle RF read data
unit_execution_vector  out  execution_vector_t  to merge unit
unit_vs2 / unit_vs1  out  VLEN each  to merge unit
unit_vd  in  VLEN  merge unit result
wb_valid  out  1  writeback entry available
wb_ready  in  1  writeback accepted
wb_addr  out  REG_ADDR_WIDTH  destination register
wb_data  out  VLEN  result data
busy  out  1  state != IDLE
done  out  1  one-cycle pulse, instruction fully written back
illegal  out  1  one-cycle pulse, issue rejected

Behaviour:
- Reset: state IDLE; credits = RESULT_FIFO_DEPTH; FIFO empty; tag pipeline cleared; element counter 0. Outputs: issue_ready=1, wb_valid=0, busy=0, done=0, illegal=0, wb_addr=0, wb_data=0. Reset mid-instruction discards all in-flight work and buffered results.
- Group size G: vlmul 000→1, 001→2, 010→4, 011→8. Fractional encodings 101/110/111→1. Encoding 100 is reserved.
- FSM IDLE: issue_ready=1. On issue_valid, the issue is illegal if vlmul=100 or any base address is not a multiple of G.
  - Illegal: illegal=1 next cycle, state stays IDLE, nothing is latched.
  - Legal: latch the execution vector, the three bases and G; counter=0; go to RUN.
- FSM RUN: issue_ready=0.
  - An element issues in any cycle with credits>0.
  - rf_vs2_addr=vs2_base+counter, rf_vs1_addr=vs1_base+counter. RF data passes straight to unit_vs2/unit_vs1.
  - Tag {valid, vd_base+counter} enters stage 0; counter increments; credits decrement.
  - Going to DRAIN: after the element with counter=G-1 issues.
  - When credits=0, the cycle is a bubble: tag valid=0, unit inputs are don't-care.
- FSM DRAIN: no issue. When credits=RESULT_FIFO_DEPTH (all results written back), pulse done=1 for one cycle and return to IDLE.
- Tag pipeline: UNIT_LATENCY register stages. When the last stage is valid, {addr, unit_vd} is pushed into the FIFO at that clock edge.
- Credits: credits can never overflow the FIFO.
  - Credits decrement on issue and increment on a wb handshake (wb_valid & wb_ready).
  - A simultaneous issue and handshake leaves credits unchanged.
- Timing: wb_valid = FIFO non-empty; wb_addr/wb_data = FIFO head, held stable while wb_valid & !wb_ready. FIFO wraps its read/write pointers modulo depth.
- Latency (UNIT_LATENCY=2, wb_ready=1):
  - issue handshake at cycle 0;
  - element 0 drives the unit at cycle 1;
  - unit_vd valid at cycle 3;
  - wb_valid at cycle 4.
  - Element i follows one cycle after element i-1.
  - done asserts the cycle after the last wb handshake.
- unit_execution_vector = latched execution vector while busy, else '0.

Decomposition:
- Add to dragonfang_pkg: vlmul encoding localparams, a merge_seq_state_t enum (IDLE, RUN, DRAIN), and a function lmul_to_group_size.
- Sub-module sync_fifo (parameterised width and depth, synchronous active-high reset) holds the result buffer.
- The tag pipeline, counter, credits and FSM stay in this module.

Test Plan:
- LMUL=1, vd=4, vs2=8, vs1=12, wb_ready=1 → rf addrs 8/12 at cycle 1; wb_valid, wb_addr=4 at cycle 4; done at cycle 5.
- LMUL=8 (011), bases 8/16/24, wb_ready=1 → wb_addr 8..15 on consecutive cycles 4..11, no bubbles; done at cycle 12.
- LMUL=8, wb_ready=0 for 20 cycles → exactly 4 elements issued, credits=0, FIFO full, no overwrite; on release all 8 results are written back in order with correct data.
- vlmul=010 with vd=6 → illegal pulse one cycle later, issue_ready stays 1, no RF or wb activity; vlmul=100 behaves the same.
- Toggle wb_ready 1/0 every cycle with LMUL=4 → simultaneous issue and handshake keeps credits stable, all 4 results are correct and wb_data is stable while stalled.
- Assert reset during RUN of an LMUL=8 instruction → next cycle IDLE, wb_valid=0, credits=4; a subsequent LMUL=1 instruction completes normally.
